led_scan: RTL and testbench
===========================

# led_scan

Time-multiplexed driver for an 8-digit common-anode seven-segment display. It takes eight 4-bit hex digit values, a per-digit decimal-point mask and a per-digit blink mask. It scans one digit at a time at a fixed refresh rate and drives active-low anode and segment lines. It sits between the clock/calendar datapath and the board display pins.

## Interface
Parameters:
- SCAN_DIV, 100000: clock cycles each digit stays selected (1 ms at 100 MHz); legal range ≥ 2.
- BLINK_DIV, 25000000: clock cycles per blink half-period (visible/blanked); legal range ≥ 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- led1Number..led8Number  input  4 each  hex value for digit 1..8; ledkNumber maps to digit index k-1.
- point  input  8  decimal-point enable; point[i]=1 lights the DP of digit i.
- is_shine  input  1  global blink enable.
- which_shine  input  8  blink mask; which_shine[i]=1 makes digit i blink when is_shine=1.
- an  output  8  anode select, active-low; an[i]=0 selects digit i.
- seg  output  8  segments, active-low; seg[6:0]=g,f,e,d,c,b,a, seg[7]=dp.

## Operation
- scan_cnt: counts 0..SCAN_DIV-1, wraps to 0.
- On the wrap, the digit index idx (3 bits) advances by one, 0→1→…→7→0.
- blink_cnt: counts 0..BLINK_DIV-1; on wrap, the blink phase bit toggles.
  - phase=1 means visible; phase=0 means blanked.
- Digit i is blanked when is_shine=1, which_shine[i]=1 and phase=0.
- Hex decode table (seg[6:0] active-low, shown as 8-bit with dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Output computed each cycle from idx:
  - an = ~(8'b1 << idx).
  - seg = {~point[idx], decode(number[idx])[6:0]}.
  - If the digit is blanked, seg=8'hFF (segments and DP off) while an still selects it.
- Inputs are sampled live; no input latching. A change appears on the next output update for the digit concerned.
- Blink phase runs continuously, independent of is_shine and of the scan.

## Timing
- Reset (reset_n=0, asynchronous):
  - scan_cnt=0, idx=0, blink_cnt=0, phase=1.
  - an=8'hFF, seg=8'hFF.
- an and seg are registers updated every clock from the current idx and inputs, giving one cycle of latency.
- First rising edge after reset release: an=8'hFE, seg shows digit 0.
- Each digit is selected for exactly SCAN_DIV cycles; a full frame is 8·SCAN_DIV cycles.
- Wrap of idx from 7 to 0 has no gap and no all-off cycle.
- Blink half-period is exactly BLINK_DIV cycles.
- Asserting reset mid-scan immediately forces both outputs to 8'hFF and restarts both counters; no partial state survives.
- Simultaneous scan wrap and blink wrap: both take effect; the output on the following cycle uses the new idx and new phase.

## Test plan
Use SCAN_DIV=4 and BLINK_DIV=64. Digits are 1..8 (led1Number=1 … led8Number=8), point=8'b00010000, which_shine=8'b00010000, is_shine=1.
- Hold reset_n=0 for 100 ns → an=8'hFF, seg=8'hFF throughout; release reset → next edge an=8'hFE, seg=8'hF9.
- Run one frame → an steps FE, FD, FB, F7, EF, DF, BF, 7F, holding each for 4 cycles.
  - Corresponding seg: F9, A4, B0, 99, 12, 82, F8, 80.
  - Digit 4 (value 5) seg=8'h12, because its DP is lit.
- Run past 64 cycles (phase=0) → while an=8'hEF, seg=8'hFF; other digits unchanged. After 128 cycles digit 4 shows 8'h12 again.
- Set is_shine=0 → digit 4 shows 8'h12 in every frame regardless of phase.
- Set led1Number=4'hF, point=0 → digit 0 shows seg=8'h8E within one scan slot of being selected.
- Assert reset_n=0 during digit 3 → outputs go to 8'hFF asynchronously. After release, scanning restarts at an=8'hFE.

Source files
------------

// File: rtl/led_scan.sv
// rtl/led_scan.sv - time-multiplexed 8-digit common-anode seven-segment scanner
//
// Purpose: scans eight hex digits one at a time, each digit held for SCAN_DIV
// clocks, with per-digit decimal point and per-digit blink (BLINK_DIV clocks
// per visible/blanked half-period). Outputs are registered, one cycle behind idx.
//
// Ports:
//   clk                     system clock, rising edge
//   reset_n                 asynchronous active-low reset
//   led1Number..led8Number  hex value of digit 0..7
//   point                   decimal-point enable per digit
//   is_shine                global blink enable
//   which_shine             per-digit blink mask
//   an                      anode select, active-low (an[i]=0 selects digit i)
//   seg                     segments, active-low {dp,g,f,e,d,c,b,a}
module led_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] led1Number,
  input  logic [3:0] led2Number,
  input  logic [3:0] led3Number,
  input  logic [3:0] led4Number,
  input  logic [3:0] led5Number,
  input  logic [3:0] led6Number,
  input  logic [3:0] led7Number,
  input  logic [3:0] led8Number,
  input  logic [7:0] point,
  input  logic       is_shine,
  input  logic [7:0] which_shine,
  output logic [7:0] an,
  output logic [7:0] seg
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          phase_q, phase_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic [3:0]    number [8];
  logic [3:0]    cur_num;
  logic [7:0]    cur_pat;
  logic          blanked;

  // Full 8-bit pattern with dp off; only bits [6:0] are used.
  function automatic logic [7:0] hex_decode(input logic [3:0] v);
    logic [7:0] p;
    case (v)
      4'h0: p = 8'hC0;
      4'h1: p = 8'hF9;
      4'h2: p = 8'hA4;
      4'h3: p = 8'hB0;
      4'h4: p = 8'h99;
      4'h5: p = 8'h92;
      4'h6: p = 8'h82;
      4'h7: p = 8'hF8;
      4'h8: p = 8'h80;
      4'h9: p = 8'h90;
      4'hA: p = 8'h88;
      4'hB: p = 8'h83;
      4'hC: p = 8'hC6;
      4'hD: p = 8'hA1;
      4'hE: p = 8'h86;
      default: p = 8'h8E;
    endcase
    return p;
  endfunction

  always_comb begin
    number[0] = led1Number;
    number[1] = led2Number;
    number[2] = led3Number;
    number[3] = led4Number;
    number[4] = led5Number;
    number[5] = led6Number;
    number[6] = led7Number;
    number[7] = led8Number;
  end

  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;

    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end

    // Blink phase free-runs regardless of is_shine so enabling blink
    // never restarts the half-period.
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    cur_num = number[idx_q];
    cur_pat = hex_decode(cur_num);
    blanked = is_shine && which_shine[idx_q] && !phase_q;

    an_d = ~(8'b1 << idx_q);
    if (blanked) begin
      seg_d = 8'hFF;
    end else begin
      seg_d = {~point[idx_q], cur_pat[6:0]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      idx_q       <= 3'd0;
      phase_q     <= 1'b1;
      an_q        <= 8'hFF;
      seg_q       <= 8'hFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_led_scan.sv
// tb/tb_led_scan.sv - directed self-checking bench for led_scan
module tb_led_scan;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] led1Number, led2Number, led3Number, led4Number;
  logic [3:0] led5Number, led6Number, led7Number, led8Number;
  logic [7:0] point;
  logic       is_shine;
  logic [7:0] which_shine;
  logic [7:0] an;
  logic [7:0] seg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] an_tab  [8];
  logic [7:0] seg_tab [8];

  led_scan #(.SCAN_DIV(4), .BLINK_DIV(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .led1Number(led1Number), .led2Number(led2Number),
    .led3Number(led3Number), .led4Number(led4Number),
    .led5Number(led5Number), .led6Number(led6Number),
    .led7Number(led7Number), .led8Number(led8Number),
    .point(point), .is_shine(is_shine), .which_shine(which_shine),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [7:0] an_exp, input logic [7:0] seg_exp);
    checks++;
    assert (an === an_exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d an observed=%h expected=%h", tag, cyc, an, an_exp);
    end
    checks++;
    assert (seg === seg_exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d seg observed=%h expected=%h", tag, cyc, seg, seg_exp);
    end
  endtask

  // Steps whole frames; digit 4 expected blank for cycles in [blank_lo, blank_hi].
  task automatic run_frames(input string tag, input int nframes, input int blank_lo, input int blank_hi);
    logic [7:0] s;
    for (int f = 0; f < nframes; f++) begin
      for (int d = 0; d < 8; d++) begin
        for (int k = 0; k < 4; k++) begin
          step();
          s = seg_tab[d];
          if (d == 4 && cyc >= blank_lo && cyc <= blank_hi) s = 8'hFF;
          chk(tag, an_tab[d], s);
        end
      end
    end
  endtask

  initial begin
    an_tab  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    seg_tab = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h12, 8'h82, 8'hF8, 8'h80};

    reset_n     = 1'b0;
    led1Number  = 4'd1; led2Number = 4'd2; led3Number = 4'd3; led4Number = 4'd4;
    led5Number  = 4'd5; led6Number = 4'd6; led7Number = 4'd7; led8Number = 4'd8;
    point       = 8'b0001_0000;
    which_shine = 8'b0001_0000;
    is_shine    = 1'b1;

    // Held in reset for 100 ns: outputs stay all-off.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("in_reset", 8'hFF, 8'hFF);
    end

    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;

    // First edge after release shows digit 0, then frames 1-2 visible,
    // frames 3-4 (cycles 65..128) blank digit 4, frame 5 visible again.
    step();
    chk("first_edge", 8'hFE, 8'hF9);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("first_slot", 8'hFE, 8'hF9);
    end
    for (int d = 1; d < 8; d++) begin
      for (int k = 0; k < 4; k++) begin
        step();
        chk("frame1", an_tab[d], seg_tab[d]);
      end
    end
    run_frames("blink", 4, 65, 128);

    // Blink disabled: digit 4 lit through the blanked phase (cycles 193..224).
    is_shine = 1'b0;
    run_frames("no_shine", 2, 1, 0);

    // Live input change: digit 0 becomes F, all DPs off.
    led1Number = 4'hF;
    point      = 8'h00;
    seg_tab[0] = 8'h8E;
    seg_tab[4] = 8'h92;
    run_frames("live_change", 1, 1, 0);

    // Advance into digit 3 and reset mid-slot.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 4; k++) begin
        step();
        chk("pre_reset", an_tab[d], seg_tab[d]);
      end
    end
    step();
    chk("digit3", 8'hF7, 8'h99);
    step();
    chk("digit3", 8'hF7, 8'h99);
    reset_n = 1'b0;
    #1;
    chk("async_reset", 8'hFF, 8'hFF);
    @(negedge clk);
    chk("reset_hold", 8'hFF, 8'hFF);
    step();
    chk("reset_hold_edge", 8'hFF, 8'hFF);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("restart", 8'hFE, 8'h8E);
    end
    step();
    chk("restart_next", 8'hFD, 8'hA4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
